// File: rtl/i2s_encode_pkg.sv
`default_nettype none
// ============================================================================
// Package     : i2s_pkg
// Description : Shared constants and types for the I2S transmit/receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  // Default sample width and slot length used by the audio path.
  localparam int RESOLUTION_DEF = 24;
  localparam int SLOT_BITS_DEF  = 32;

  // Word-clock channel select; the encoding is the LRCK level itself.
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } lr_t;

  // Stereo sample pair as exchanged with the decoder stage.
  typedef struct packed {
    logic [RESOLUTION_DEF-1:0] left;
    logic [RESOLUTION_DEF-1:0] right;
  } stereo_t;

endpackage
`default_nettype wire

// File: rtl/i2s_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : i2s_clk_div
// Description : Bit-clock generator for master-mode audio blocks. Divides the
//               system clock into SCLK and provides single-cycle strobes for
//               the cycles in which SCLK rises and falls.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clk_div #(
  parameter int DIV_HALF = 2
) (
  input  logic CLK,
  input  logic RST_N,
  output logic SCLK,
  output logic rise,
  output logic fall
);

  // A single-cycle half-period still needs a one-bit counter to stay legal.
  localparam int            CW      = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_HALF - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;
  logic          sclk_q;
  logic          wrap;

  assign wrap = (div_cnt_q == CNT_MAX);
  assign rise = wrap & ~sclk_q;
  assign fall = wrap & sclk_q;
  assign SCLK = sclk_q;

  // Half-period counter wraps to zero on the cycle SCLK toggles.
  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
  end

  // Counter and bit-clock state; SCLK toggles on every counter wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      if (wrap) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_encode.sv
`default_nettype none
// ============================================================================
// Module      : i2s_encode
// Description : I2S master transmitter. Accepts one stereo pair per frame via
//               a valid/ready handshake into a one-entry buffer, and
//               serializes it MSB-first with the standard one-bit delay after
//               each word-clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_encode
  import i2s_pkg::*;
#(
  parameter int RESOLUTION = RESOLUTION_DEF,
  parameter int SLOT_BITS  = SLOT_BITS_DEF,
  parameter int DIV_HALF   = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [RESOLUTION-1:0] sample_L,
  input  logic [RESOLUTION-1:0] sample_R,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  SCLK,
  output logic                  LRCK,
  output logic                  data_out,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int            FRAME_BITS = 2 * SLOT_BITS;
  localparam int            BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_MAX    = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_B     = BW'(SLOT_BITS);

  logic sclk_fall;
  logic sclk_rise_unused;

  i2s_clk_div #(
    .DIV_HALF (DIV_HALF)
  ) u_clk_div (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SCLK  (SCLK),
    .rise  (sclk_rise_unused),
    .fall  (sclk_fall)
  );

  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  lr_t                   lrck_q, lrck_d;
  logic                  data_q, data_d;
  logic                  fs_q, fs_d;
  logic                  ur_q, ur_d;
  logic                  buf_empty_q, buf_empty_d;
  logic [RESOLUTION-1:0] buf_l_q, buf_l_d;
  logic [RESOLUTION-1:0] buf_r_q, buf_r_d;
  logic [RESOLUTION-1:0] hold_l_q, hold_l_d;
  logic [RESOLUTION-1:0] hold_r_q, hold_r_d;

  logic                  accept;
  logic [BW-1:0]         b_next;
  logic [BW-1:0]         pos;
  logic [RESOLUTION-1:0] active;

  assign accept       = sample_valid & buf_empty_q;
  assign sample_ready = buf_empty_q;
  assign LRCK         = lrck_q;
  assign data_out     = data_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;

  // Slot sequencing on SCLK falls, frame-start buffer transfer and handshake.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    lrck_d      = lrck_q;
    data_d      = data_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    buf_empty_d = buf_empty_q;
    buf_l_d     = buf_l_q;
    buf_r_d     = buf_r_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;

    b_next = (bit_cnt_q == BIT_MAX) ? '0 : bit_cnt_q + 1'b1;
    pos    = (b_next >= SLOT_B) ? b_next - SLOT_B : b_next;
    active = (b_next >= SLOT_B) ? hold_r_q : hold_l_q;

    if (sclk_fall) begin
      bit_cnt_d = b_next;
      lrck_d    = (b_next >= SLOT_B) ? RIGHT : LEFT;

      // Slot position 0 is the one-bit I2S delay; positions past the sample
      // width pad with zeros. Position 0 also covers the holding-register
      // reload, so using the old holding value here is harmless.
      data_d = 1'b0;
      for (int k = 1; k <= RESOLUTION; k++) begin
        if (pos == BW'(k)) begin
          data_d = active[RESOLUTION-k];
        end
      end

      if (b_next == '0) begin
        fs_d = 1'b1;
        if (buf_empty_q) begin
          hold_l_d = '0;
          hold_r_d = '0;
          ur_d     = 1'b1;
        end else begin
          hold_l_d    = buf_l_q;
          hold_r_d    = buf_r_q;
          buf_empty_d = 1'b1;
        end
      end
    end

    // Accept only into an empty buffer, so this never collides with the
    // frame-start drain above.
    if (accept) begin
      buf_l_d     = sample_L;
      buf_r_d     = sample_R;
      buf_empty_d = 1'b0;
    end
  end

  // State registers; reset leaves LRCK high so the first frame sees an edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt_q   <= BIT_MAX;
      lrck_q      <= RIGHT;
      data_q      <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      buf_empty_q <= 1'b1;
      buf_l_q     <= '0;
      buf_r_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      lrck_q      <= lrck_d;
      data_q      <= data_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      buf_empty_q <= buf_empty_d;
      buf_l_q     <= buf_l_d;
      buf_r_q     <= buf_r_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/i2s_encode.md
# i2s_encode

I2S master transmitter for the audio path. It takes one stereo pair of parallel samples per frame through a valid/ready handshake and serializes them MSB-first. It generates the bit clock (`SCLK`), word clock (`LRCK`) and serial data from the single system clock. It sits directly upstream of the I2S receiver/decoder stage, and its outputs wire straight to that stage's `SCLK`, `LRCK` and `data_in`.

## Interface
- `RESOLUTION`, 24: sample width in bits; MSB-first on the wire.
- `SLOT_BITS`, 32: `SCLK` periods per channel slot; must be ≥ `RESOLUTION`+1.
- `DIV_HALF`, 2: `CLK` cycles per `SCLK` half-period; must be ≥ 1.
- `CLK`  in  1  system clock; the only clock.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `sample_L`  in  `RESOLUTION`  left sample, two's complement.
- `sample_R`  in  `RESOLUTION`  right sample.
- `sample_valid`  in  1  sample pair present.
- `sample_ready`  out  1  one-entry input buffer empty.
- `SCLK`  out  1  bit clock; data is stable across its rising edge.
- `LRCK`  out  1  word clock; 0 = left slot, 1 = right slot.
- `data_out`  out  1  serial data.
- `frame_start`  out  1  one-`CLK` pulse at each left-slot start.
- `underrun`  out  1  one-`CLK` pulse: frame started with the buffer empty.

## Operation
- **Clock divider.** `div_cnt` counts 0..`DIV_HALF`-1 and toggles `SCLK` on wrap. The cycle where `SCLK` goes 1→0 is the `fall` strobe. All slot logic advances only on `fall`.
- **Bit counter.** `bit_cnt` counts 0..2·`SLOT_BITS`-1 and wraps to 0. On each `fall`, `bit_cnt` advances. Outputs are then driven for the new count `b`.
  - `LRCK` = (`b` ≥ `SLOT_BITS`).
  - Slot position `p` = `b` mod `SLOT_BITS`.
  - `data_out` = `shift[RESOLUTION-p]` of the active channel for `p` in 1..`RESOLUTION`; otherwise 0.
  - This gives the standard one-`SCLK` I2S delay: the MSB follows the `LRCK` edge by one bit.
- **Frame start.** On the `fall` where `b` becomes 0, `frame_start` pulses.
  - Buffer full: the buffer copies into the L/R shift holding registers and the buffer empties.
  - Buffer empty: the holding registers load 0 and `underrun` pulses in the same cycle.
- **Handshake.**
  - `sample_ready` = buffer empty; it comes from a register, with no combinational path from `sample_valid`.
  - Transfer occurs on `sample_valid` & `sample_ready` at a `CLK` edge.
  - The underrun decision uses the buffer state at the start of the cycle. A pair accepted in the frame-start cycle lands in the buffer for the next frame, and `underrun` still pulses.
- **Data handling.** No arithmetic on data. Samples pass bit-exact; the sign bit is sent first.

## Timing
- **Reset values:**
  - `SCLK`=0, `LRCK`=1, `data_out`=0, `sample_ready`=1, `frame_start`=0, `underrun`=0.
  - Internally: `div_cnt`=0, `bit_cnt`=2·`SLOT_BITS`-1, buffer empty, holding registers 0.
- **Start-up.** First `SCLK` rise at `CLK` cycle `DIV_HALF`. First `fall` (frame start, `LRCK` 1→0) at cycle 2·`DIV_HALF`. The reset value `LRCK`=1 guarantees a word-clock edge for the first frame.
- **Output registration.** All outputs are registered and change only on `fall` cycles. Exceptions: `sample_ready`, and `SCLK` at the rise.
- **Latency.** For a pair accepted before frame start N, its MSB appears on `data_out` at the second `fall` of frame N. Its left LSB appears at `p`=`RESOLUTION`.
- **Throughput.** One pair per 2·`SLOT_BITS`·2·`DIV_HALF` `CLK` cycles. Excess `sample_valid` stalls with `sample_ready`=0.
- **Mid-operation reset.** Asserting `RST_N` mid-frame returns everything to reset values immediately. Any buffered sample is discarded.

## Structure
- **Package `i2s_pkg`:**
  - Default `RESOLUTION`/`SLOT_BITS` constants.
  - An `lr_t` enum (LEFT=0, RIGHT=1).
  - The stereo sample struct shared with the decoder stage.
- **Sub-module `i2s_clk_div`:**
  - Parameter `DIV_HALF`.
  - Outputs `SCLK`, `rise` and `fall` strobes.
  - Reusable by other master-mode audio blocks.

## Test plan
- **Reset.** Hold `RST_N`=0 → `SCLK`=0, `LRCK`=1, `data_out`=0, `sample_ready`=1, no pulses. Release → `LRCK` falls at `CLK` cycle 4 (`DIV_HALF`=2).
- **Loopback.** Defaults; send L=0xA5A5A5, R=0x3C3C3C, wired into the decoder stage.
  - Serial stream is 0, then 24 bits of 0xA5A5A5, then 7 zeros, then likewise for R.
  - Decoder outputs `data_out_L`=0xA5A5A5 and `data_out_R`=0x3C3C3C after the following `LRCK` edge.
- **Underrun.** No `sample_valid` → `underrun` pulses coincident with every `frame_start` and `data_out` stays 0. A late pair arriving in the frame-start cycle transmits in the next frame.
- **Backpressure.** `sample_valid` held high with incrementing data → exactly one pair is accepted per frame, and `sample_ready` reasserts only after each `frame_start`. The transmitted sequence has no gaps or duplicates.
- **Boundary.** `SLOT_BITS`=25, L=0x800001 → LSB 1 at `p`=24, then `p`=0 of the right slot is 0, and `LRCK` toggles every 25 bits.
- **Async reset.** Reset mid-right-slot → outputs return to reset values within the reset cycle. The next frame starts cleanly and reports underrun.
